ofmap_collector: RTL and testbench

- Receiving end of the accelerator's output-feature-map stream.
- Captures every o_ofmap/o_ofmap_valid beat that top emits and buffers it in a first-word-fall-through FIFO.
- Presents the buffered results to the host over a ready/valid read port.
- Tracks top's o_done to report when the layer's results have been fully drained, with beat counting and sticky error flags.

---
 rtl/ofmap_collector.sv | 177 +++++++++++++++++
 tb/tb_ofmap_collector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_collector.sv
// ofmap_collector: captures the output-feature-map beat stream from the
// accelerator into a first-word-fall-through FIFO. The host drains it over a
// ready/valid port. A small state machine follows the accelerator's done
// indication and reports when the layer has been fully drained. The block
// also keeps a saturating beat counter and sticky overflow/late flags.
module ofmap_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_clear,
  input  logic [2*DATA_WIDTH-1:0]     i_ofmap,
  input  logic                        i_ofmap_valid,
  input  logic                        i_done,
  output logic [2*DATA_WIDTH-1:0]     o_rd_data,
  output logic                        o_rd_valid,
  input  logic                        i_rd_ready,
  output logic [$clog2(DEPTH):0]      o_level,
  output logic                        o_full,
  output logic [CNT_WIDTH-1:0]        o_count,
  output logic                        o_overflow,
  output logic                        o_late,
  output logic                        o_drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = 2 * DATA_WIDTH;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t               state_reg;
  logic [WW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          level_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 overflow_reg;
  logic                 late_reg;
  logic                 drained_reg;

  logic                 rd_valid;
  logic                 full;
  logic                 accepting;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 late_beat;

  // Occupancy comes from the explicit level counter, so the full and empty
  // conditions never need pointer comparison.
  assign rd_valid  = (level_reg != '0);
  assign full      = (level_reg == LEVEL_FULL);
  assign accepting = (state_reg != ST_DONE);
  assign pop       = rd_valid && i_rd_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a beat.
  assign push      = i_ofmap_valid && accepting && (!full || pop);
  assign drop      = i_ofmap_valid && accepting && full && !pop;
  assign late_beat = i_ofmap_valid && !accepting;

  // The head word falls through combinationally. It is forced to zero while
  // empty so the port reads zero straight out of reset.
  assign o_rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
  assign o_rd_valid = rd_valid;
  assign o_level    = level_reg;
  assign o_full     = full;
  assign o_count    = count_reg;
  assign o_overflow = overflow_reg;
  assign o_late     = late_reg;
  assign o_drained  = drained_reg;

  // Storage write. The contents are don't-care after reset, so this block has no reset.
  always_ff @(posedge i_clk) begin
    if (push && !i_clear) begin
      mem[wr_ptr_reg] <= i_ofmap;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (i_clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Saturating accepted-beat counter and the sticky error flags.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      late_reg     <= 1'b0;
    end else if (i_clear) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      late_reg     <= 1'b0;
    end else begin
      if (push && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (late_beat) begin
        late_reg <= 1'b1;
      end
    end
  end

  // Layer-progress state machine. The drained output is registered and rises
  // together with the entry into DONE.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg   <= ST_IDLE;
      drained_reg <= 1'b0;
    end else if (i_clear) begin
      state_reg   <= ST_IDLE;
      drained_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // A done arriving together with the first beat still ends the
          // layer. The beat itself is pushed by the datapath.
          if (i_done) begin
            state_reg <= ST_FLUSH;
          end else if (i_ofmap_valid) begin
            state_reg <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (i_done) begin
            state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((level_reg == '0) && !push) begin
            state_reg   <= ST_DONE;
            drained_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg   <= ST_DONE;
          drained_reg <= 1'b1;
        end
        default: begin
          state_reg   <= ST_IDLE;
          drained_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_collector.sv
// Testbench for ofmap_collector. The stimulus pushes each beat it expects the
// collector to accept into a scoreboard queue. A negedge monitor pops the
// queue on every read handshake and compares the word it pops.
module tb_ofmap_collector;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = 16;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic [2*DW-1:0] ofmap;
  logic            ofmap_valid;
  logic            done;
  logic [2*DW-1:0] rd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [4:0]      level;
  logic            full;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            late;
  logic            drained;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [15:0]     sb[$];

  ofmap_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .i_clk(clk),
    .i_nrst(rst_n),
    .i_clear(clear),
    .i_ofmap(ofmap),
    .i_ofmap_valid(ofmap_valid),
    .i_done(done),
    .o_rd_data(rd_data),
    .o_rd_valid(rd_valid),
    .i_rd_ready(rd_ready),
    .o_level(level),
    .o_full(full),
    .o_count(count),
    .o_overflow(overflow),
    .o_late(late),
    .o_drained(drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat for one cycle. The valid line is left high so consecutive
  // calls give back-to-back beats.
  task automatic beat(input logic [15:0] d, input bit accept);
    ofmap       = d;
    ofmap_valid = 1'b1;
    if (accept) sb.push_back(d);
    tick();
  endtask

  task automatic idle(input int n);
    ofmap_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    sb.delete();
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (drained) break;
      tick();
    end
    check("wait_drained", drained, 1);
  endtask

  // Scoreboard monitor: one line per read transaction.
  initial begin
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n && !clear) begin
        check("level_bound", (level <= 5'd16), 1);
        if (rd_valid && rd_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pop: got 0x%04h with empty scoreboard", rd_data);
          end else begin
            exp_w = sb.pop_front();
            check("pop_data", rd_data, exp_w);
            $display("pop data=0x%04h exp=0x%04h level=%0d", rd_data, exp_w, level);
          end
        end
      end
    end
  end

  initial begin
    int c;
    rst_n       = 1'b0;
    clear       = 1'b0;
    ofmap       = '0;
    ofmap_valid = 1'b0;
    done        = 1'b0;
    rd_ready    = 1'b0;
    #2;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_count", count, 0);
    check("rst_flags", {full, overflow, late, drained}, 0);
    check("rst_rd_data", rd_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic stream of 8 beats with the host always ready.
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(16'(i), 1'b1);
      if (i == 1) begin
        check("basic_first_valid", rd_valid, 1);
        check("basic_first_data", rd_data, 16'h0001);
      end
    end
    ofmap_valid = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("basic_not_drained_yet", drained, 0);
    check("basic_level_empty", level, 0);
    tick();
    check("basic_drained", drained, 1);
    check("basic_count", count, 8);
    check("basic_overflow", overflow, 0);

    // Overflow: 20 beats into a stalled FIFO; only the first 16 survive.
    do_clear();
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat(16'h0100 + 16'(i), i < 16);
      if (i == 15) check("ovf_full_at_16", full, 1);
    end
    idle(1);
    check("ovf_full", full, 1);
    check("ovf_level", level, 16);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    rd_ready = 1'b1;
    idle(18);
    check("ovf_drained_level", level, 0);
    check("ovf_flag_sticky", overflow, 1);

    // Full FIFO with a beat and a pop in the same cycle.
    do_clear();
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(16'h0200 + 16'(i), 1'b1);
    rd_ready = 1'b1;
    beat(16'h0AAA, 1'b1);
    rd_ready = 1'b0;
    idle(1);
    check("fullpop_level", level, 16);
    check("fullpop_overflow", overflow, 0);
    check("fullpop_count", count, 17);
    rd_ready = 1'b1;
    idle(18);
    check("fullpop_empty", level, 0);

    // Done with pending data, then a late beat.
    do_clear();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(16'h0300 + 16'(i), 1'b1);
    ofmap_valid = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("pend_not_drained", drained, 0);
    check("pend_level", level, 4);
    rd_ready = 1'b1;
    wait_drained(20);
    beat(16'hBEEF, 1'b0);
    idle(1);
    check("late_flag", late, 1);
    check("late_count", count, 4);
    check("late_rd_valid", rd_valid, 0);
    check("late_overflow", overflow, 0);

    // Wrap-around: 40 beats, ready toggling every cycle.
    do_clear();
    c = 0;
    for (int i = 0; i < 40; i++) begin
      rd_ready = (c % 2) == 1;
      beat(16'h0400 + 16'(i), 1'b1);
      c++;
      if (i >= 20) begin
        ofmap_valid = 1'b0;
        rd_ready = (c % 2) == 1;
        tick();
        c++;
      end
    end
    ofmap_valid = 1'b0;
    rd_ready = 1'b1;
    idle(20);
    check("wrap_count", count, 40);
    check("wrap_overflow", overflow, 0);
    check("wrap_empty", level, 0);

    // Clear concurrent with a beat discards the beat and all state.
    do_clear();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(16'h0500 + 16'(i), 1'b1);
    ofmap = 16'h0999;
    ofmap_valid = 1'b1;
    clear = 1'b1;
    sb.delete();
    tick();
    clear = 1'b0;
    ofmap_valid = 1'b0;
    check("clr_level", level, 0);
    check("clr_count", count, 0);
    check("clr_rd_valid", rd_valid, 0);
    check("clr_flags", {full, overflow, late, drained}, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("clr_idle_to_done", drained, 1);

    // Asynchronous reset in the middle of a stream.
    do_clear();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat(16'h0600 + 16'(i), 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_level", level, 0);
    check("arst_count", count, 0);
    check("arst_flags", {full, overflow, late, drained}, 0);
    ofmap_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(2);
    check("arst_count_after", count, 0);

    check("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
